// File: rtl/serial_bus_arbiter.sv
// serial_bus_arbiter: central arbiter for the serial bus.
// Collects per-master requests and issues a registered one-hot grant. Unused grants are
// revoked after GRANT_TIMEOUT cycles. A split master is parked and later given priority.
// Optional feature: define SERIAL_BUS_ARB_ROUND_ROBIN_EN for round-robin priority.
// Without it, fixed priority applies (lowest index wins).
module serial_bus_arbiter #(
    parameter int unsigned MASTER_NO     = 2,
    parameter int unsigned SLAVE_NO      = 5,
    parameter int unsigned GRANT_TIMEOUT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [MASTER_NO-1:0]         bus_req,
    input  logic [MASTER_NO-1:0]         bus_util,
    input  logic [SLAVE_NO-1:0]          s_split,
    input  logic [SLAVE_NO-1:0]          s_split_resume,
    output logic [MASTER_NO-1:0]         bus_grant,
    output logic [MASTER_NO-1:0]         split_en,
    output logic [$clog2(MASTER_NO)-1:0] grant_id,
    output logic                         bus_busy,
    output logic                         split_pending
);

    localparam int unsigned MW = $clog2(MASTER_NO);
    localparam int unsigned SW = (SLAVE_NO > 1) ? $clog2(SLAVE_NO) : 1;
    localparam int unsigned CW = $clog2(GRANT_TIMEOUT);
    localparam logic [CW-1:0] CntMax = CW'(GRANT_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StGrant, StBusy} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic [MW-1:0]  split_master_q;
    logic [SW-1:0]  split_slave_q;
    logic           resumed_q;
`ifdef SERIAL_BUS_ARB_ROUND_ROBIN_EN
    logic [MW-1:0]  rr_ptr_q;
`endif

    logic [MASTER_NO-1:0] elig;
    logic [MASTER_NO-1:0] win_oh;
    logic [MASTER_NO-1:0] own_oh;
    logic [MW-1:0]        win;
    logic [SW-1:0]        split_lo;
    logic                 any_elig;
    logic                 resume_hit;
    logic                 pend_eff;

    // Resume is evaluated ahead of a split arriving in the same cycle.
    assign resume_hit = split_pending && s_split_resume[split_slave_q];
    assign pend_eff   = split_pending && !resume_hit;
    assign win_oh     = MASTER_NO'(1) << win;
    assign own_oh     = MASTER_NO'(1) << grant_id;
    assign bus_busy   = (state_q != StIdle);

    // Eligible requests: a parked split master may not be granted.
    always_comb begin
        elig = bus_req;
        if (split_pending) begin
            elig[split_master_q] = 1'b0;
        end
    end

    // Winner selection: a resumed split master wins outright, else the priority scheme.
    always_comb begin
        win      = '0;
        any_elig = 1'b0;
        if (!split_pending && resumed_q && bus_req[split_master_q]) begin
            win      = split_master_q;
            any_elig = 1'b1;
        end else begin
`ifdef SERIAL_BUS_ARB_ROUND_ROBIN_EN
            // Descending loop so the smallest offset from the pointer wins last.
            for (int k = int'(MASTER_NO); k >= 1; k--) begin
                int idx;
                idx = (int'(rr_ptr_q) + k) % int'(MASTER_NO);
                if (elig[idx]) begin
                    win      = MW'(idx);
                    any_elig = 1'b1;
                end
            end
`else
            for (int i = int'(MASTER_NO) - 1; i >= 0; i--) begin
                if (elig[i]) begin
                    win      = MW'(i);
                    any_elig = 1'b1;
                end
            end
`endif
        end
    end

    // Lowest-index slave requesting a split.
    always_comb begin
        split_lo = '0;
        for (int j = int'(SLAVE_NO) - 1; j >= 0; j--) begin
            if (s_split[j]) begin
                split_lo = SW'(j);
            end
        end
    end

    // Arbitration FSM with registered grant, split command and split bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            bus_grant      <= '0;
            split_en       <= '0;
            grant_id       <= '0;
            cnt_q          <= '0;
            split_master_q <= '0;
            split_slave_q  <= '0;
            split_pending  <= 1'b0;
            resumed_q      <= 1'b0;
`ifdef SERIAL_BUS_ARB_ROUND_ROBIN_EN
            rr_ptr_q       <= '0;
`endif
        end else begin
            split_en <= '0;
            if (resume_hit) begin
                split_pending <= 1'b0;
                resumed_q     <= 1'b1;
            end
            unique case (state_q)
                StIdle: begin
                    if (any_elig) begin
                        state_q   <= StGrant;
                        bus_grant <= win_oh;
                        grant_id  <= win;
                        cnt_q     <= '0;
                        if (win == split_master_q) begin
                            resumed_q <= 1'b0;
                        end
`ifdef SERIAL_BUS_ARB_ROUND_ROBIN_EN
                        rr_ptr_q  <= win;
`endif
                    end else begin
                        bus_grant <= '0;
                    end
                end
                StGrant: begin
                    if (bus_util[grant_id]) begin
                        state_q <= StBusy;
                    end else if (!bus_req[grant_id]) begin
                        state_q   <= StIdle;
                        bus_grant <= '0;
                    end else if (cnt_q == CntMax) begin
                        state_q   <= StIdle;
                        bus_grant <= '0;
`ifdef SERIAL_BUS_ARB_ROUND_ROBIN_EN
                        rr_ptr_q  <= grant_id;
`endif
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StBusy: begin
                    if (!bus_util[grant_id]) begin
                        state_q   <= StIdle;
                        bus_grant <= '0;
                    end else if ((|s_split) && !pend_eff) begin
                        split_en       <= own_oh;
                        split_master_q <= grant_id;
                        split_slave_q  <= split_lo;
                        split_pending  <= 1'b1;
                        state_q        <= StIdle;
                        bus_grant      <= '0;
                    end
                end
                default: begin
                    state_q   <= StIdle;
                    bus_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_bus_arbiter.sv
// Self-checking bench for serial_bus_arbiter: directed test-plan steps followed by a
// randomized phase, all checked against a transaction-level reference model.
module tb_serial_bus_arbiter;

    localparam int M = 2;
    localparam int S = 5;
    localparam int T = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [M-1:0]         bus_req;
    logic [M-1:0]         bus_util;
    logic [S-1:0]         s_split;
    logic [S-1:0]         s_split_resume;
    logic [M-1:0]         bus_grant;
    logic [M-1:0]         split_en;
    logic [$clog2(M)-1:0] grant_id;
    logic                 bus_busy;
    logic                 split_pending;

    int checks = 0;
    int errors = 0;

    // Reference model: owner index (-1 = bus free), whether the grant has been used, its age,
    // the parked master (-1 = none) and its slave, the master owed priority (-1 = none).
    int m_owner, m_used, m_age, m_last, m_parked, m_slave, m_resumed, m_ptr, m_split_en;

    always #5 clk = ~clk;

    serial_bus_arbiter #(
        .MASTER_NO     (M),
        .SLAVE_NO      (S),
        .GRANT_TIMEOUT (T)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .bus_req        (bus_req),
        .bus_util       (bus_util),
        .s_split        (s_split),
        .s_split_resume (s_split_resume),
        .bus_grant      (bus_grant),
        .split_en       (split_en),
        .grant_id       (grant_id),
        .bus_busy       (bus_busy),
        .split_pending  (split_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Fixed priority is a round-robin search that always starts at master 0.
    task automatic model_reset();
        m_owner = -1; m_used = 0; m_age = 0; m_last = 0;
        m_parked = -1; m_slave = 0; m_resumed = -1; m_split_en = 0;
`ifdef SERIAL_BUS_ARB_ROUND_ROBIN_EN
        m_ptr = 0;
`else
        m_ptr = M - 1;
`endif
    endtask

    task automatic model_edge();
        int p0 = m_parked;
        int r0 = m_resumed;
        int w = -1;
        int lo = -1;
        logic [M-1:0] elig;
        m_split_en = 0;
        if (m_parked >= 0 && s_split_resume[m_slave]) begin
            m_resumed = m_parked;
            m_parked  = -1;
        end
        if (m_owner < 0) begin
            elig = bus_req;
            if (p0 >= 0) elig[p0] = 1'b0;
            if (p0 < 0 && r0 >= 0 && bus_req[r0]) begin
                w = r0;
            end else begin
                for (int k = 1; k <= M; k++) begin
                    int c = (m_ptr + k) % M;
                    if (w < 0 && elig[c]) w = c;
                end
            end
            if (w >= 0) begin
                m_owner = w; m_used = 0; m_age = 0; m_last = w;
                if (w == m_resumed) m_resumed = -1;
`ifdef SERIAL_BUS_ARB_ROUND_ROBIN_EN
                m_ptr = w;
`endif
            end
        end else if (m_used == 0) begin
            if (bus_util[m_owner]) begin
                m_used = 1;
            end else if (!bus_req[m_owner]) begin
                m_owner = -1;
            end else if (m_age == T - 1) begin
`ifdef SERIAL_BUS_ARB_ROUND_ROBIN_EN
                m_ptr = m_owner;
`endif
                m_owner = -1;
            end else begin
                m_age++;
            end
        end else begin
            if (!bus_util[m_owner]) begin
                m_owner = -1;
            end else if (s_split != '0 && m_parked < 0) begin
                for (int j = S - 1; j >= 0; j--) if (s_split[j]) lo = j;
                m_split_en = 1 << m_owner;
                m_parked   = m_owner;
                m_slave    = lo;
                m_owner    = -1;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".grant"}, 32'(bus_grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk({tag, ".split_en"}, 32'(split_en), 32'(m_split_en));
        chk({tag, ".grant_id"}, 32'(grant_id), 32'(m_last));
        chk({tag, ".busy"}, 32'(bus_busy), 32'(m_owner >= 0));
        chk({tag, ".split_pending"}, 32'(split_pending), 32'(m_parked >= 0));
    endtask

    // One clock: model consumes the inputs sampled at this edge, outputs checked 1 ns later.
    task automatic step(input string tag);
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1; bus_req = '0; bus_util = '0; s_split = '0; s_split_resume = '0;
        step("reset");
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        chk("reset_grant", 32'(bus_grant), 32'd0);
        chk("reset_pending", 32'(split_pending), 32'd0);

        // Single master
        bus_req = 2'b10;
        step("single_req");
        chk("single_grant", 32'(bus_grant), 32'h2);
        bus_util = 2'b10;
        for (int i = 0; i < 20; i++) step("single_busy");
        chk("single_hold", 32'(bus_grant), 32'h2);
        bus_util = '0; bus_req = '0;
        step("single_release");
        chk("single_drop", 32'(bus_grant), 32'h0);

        // Contention
        do_reset();
        bus_req = 2'b11;
        for (int g = 0; g < 4; g++) begin
            step("cont_arb");
`ifdef SERIAL_BUS_ARB_ROUND_ROBIN_EN
            chk("cont_id", 32'(grant_id), (g % 2 == 0) ? 32'd1 : 32'd0);
`else
            chk("cont_id", 32'(grant_id), 32'd0);
`endif
            bus_util = bus_grant;
            for (int i = 0; i < 5; i++) step("cont_busy");
            bus_util = '0;
            step("cont_release");
        end

        // Timeout
        do_reset();
        bus_req = 2'b01;
        step("to_req");
        chk("to_grant", 32'(bus_grant), 32'h1);
        bus_req = 2'b11;
        for (int i = 1; i < T; i++) begin
            step("to_wait");
            chk("to_hold", 32'(bus_grant), 32'h1);
        end
        step("to_expire");
        chk("to_drop", 32'(bus_grant), 32'h0);
        step("to_next");
`ifdef SERIAL_BUS_ARB_ROUND_ROBIN_EN
        chk("to_next_grant", 32'(bus_grant), 32'h2);
`else
        chk("to_next_grant", 32'(bus_grant), 32'h1);
`endif

        // Split and resume
        do_reset();
        bus_req = 2'b01;
        step("sp_req");
        bus_util = 2'b01;
        step("sp_use");
        step("sp_busy");
        s_split = 5'b01000;
        step("sp_split");
        chk("sp_en", 32'(split_en), 32'h1);
        chk("sp_grant_drop", 32'(bus_grant), 32'h0);
        chk("sp_pending", 32'(split_pending), 32'd1);
        s_split = '0; bus_req = 2'b11; bus_util = '0;
        step("sp_other");
        chk("sp_en_clear", 32'(split_en), 32'h0);
        chk("sp_m1_grant", 32'(bus_grant), 32'h2);
        bus_util = 2'b10;
        step("sp_m1_busy");
        s_split_resume = 5'b00100;
        step("sp_wrong_resume");
        chk("sp_wrong_keep", 32'(split_pending), 32'd1);
        s_split_resume = 5'b01000;
        step("sp_resume");
        chk("sp_resume_clear", 32'(split_pending), 32'd0);
        s_split_resume = '0; bus_util = '0;
        step("sp_m1_release");
        step("sp_rearb");
        chk("sp_resumed_wins", 32'(bus_grant), 32'h1);

        // Reset mid-BUSY
        bus_util = 2'b01;
        step("rst_busy");
        rst = 1'b1;
        step("rst_mid");
        chk("rst_mid_grant", 32'(bus_grant), 32'h0);
        chk("rst_mid_busy", 32'(bus_busy), 32'd0);
        rst = 1'b0; bus_util = '0;
        step("rst_after");
`ifdef SERIAL_BUS_ARB_ROUND_ROBIN_EN
        chk("rst_regrant", 32'(bus_grant), 32'h2);
`else
        chk("rst_regrant", 32'(bus_grant), 32'h1);
`endif

        // Randomized phase
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rst            = ($urandom % 150) == 0;
            bus_req        = M'($urandom);
            for (int b = 0; b < M; b++) bus_util[b] = ($urandom % 8) != 0;
            s_split        = (($urandom % 6) == 0) ? S'($urandom) : '0;
            s_split_resume = (($urandom % 6) == 0) ? S'($urandom) : '0;
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
